// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the packetised memory loader and the host driver
//   model: header field positions and extractors, FSM state type, and the
//   bit positions of the sticky error flags.
//   Header word layout (32 bits):
//     [MEM_ADDR_WIDTH-1:0]        start address
//     [15:MEM_ADDR_WIDTH]         ignored
//     [16+len_width-1:16]         burst length minus one
//     [31:16+len_width]           reserved, must be zero
package mem_loader_pkg;

  localparam int unsigned HDR_LEN_LSB = 16;

  // Positions inside the err vector {err_hdr, err_long, err_short}
  localparam int unsigned ERR_SHORT = 0;
  localparam int unsigned ERR_LONG  = 1;
  localparam int unsigned ERR_HDR   = 2;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Length-minus-one field, zero-extended to 32 bits.
  function automatic logic [31:0] hdr_len_m1(input logic [31:0] word,
                                             input int unsigned len_width);
    return (word >> HDR_LEN_LSB) & ((32'd1 << len_width) - 32'd1);
  endfunction

  // True when any reserved bit above the length field is set.
  function automatic logic hdr_rsvd_nonzero(input logic [31:0] word,
                                            input int unsigned len_width);
    return (word >> (HDR_LEN_LSB + len_width)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_addr_incr.sv
// mem_addr_incr
//   Combinational next-address for a burst write.
//   Cmd region (MSB = 0): only the low CMD_ADDR_WIDTH bits count and wrap,
//   so cmd_sel, the unused bits and the MSB are held.
//   Wave region (MSB = 1): all bits below the MSB count and wrap.
//   Ports:
//     addr       in   MEM_ADDR_WIDTH  current write address
//     addr_next  out  MEM_ADDR_WIDTH  address for the following word
module mem_addr_incr #(
  parameter int unsigned MEM_ADDR_WIDTH = 13,
  parameter int unsigned CMD_ADDR_WIDTH = 8
) (
  input  logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic [MEM_ADDR_WIDTH-1:0] addr_next
);

  localparam logic [MEM_ADDR_WIDTH-2:0] WAVE_ONE = 1;
  localparam logic [CMD_ADDR_WIDTH-1:0] CMD_ONE  = 1;

  always_comb begin
    addr_next = addr;
    if (addr[MEM_ADDR_WIDTH-1]) begin
      addr_next[MEM_ADDR_WIDTH-2:0] = addr[MEM_ADDR_WIDTH-2:0] + WAVE_ONE;
    end else begin
      addr_next[CMD_ADDR_WIDTH-1:0] = addr[CMD_ADDR_WIDTH-1:0] + CMD_ONE;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
//   Host-side writer for the per-channel memory write bus. Accepts a
//   packetised valid/ready stream (one header word followed by payload
//   words) and issues one registered memory write per payload word.
//   Ports:
//     clk             in   1               clock
//     reset           in   1               synchronous, active-high reset
//     hold            in   1               1 = stop accepting beats
//     s_data          in   DATA_WIDTH      stream word
//     s_valid         in   1               stream word valid
//     s_last          in   1               final word of packet
//     s_ready         out  1               stream ready (= ~hold)
//     mem_write_addr  out  MEM_ADDR_WIDTH  memory write address
//     mem_write_data  out  DATA_WIDTH      memory write data
//     mem_write_en    out  1               memory write strobe
//     busy            out  1               packet in progress
//     done            out  1               pulse: packet completed cleanly
//     err             out  3               sticky {err_hdr, err_long, err_short}
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 13,
  parameter int unsigned CMD_ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic                      mem_write_en,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                err
);

  localparam logic [LEN_WIDTH-1:0] CNT_ONE = 1;

  state_t                    state;
  state_t                    state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_inc;
  logic [LEN_WIDTH-1:0]      cnt_r;
  logic [2:0]                err_r;

  logic                      accept;
  logic                      hdr_rsvd;
  logic                      load_hdr;
  logic                      do_write;
  logic                      done_set;
  logic [2:0]                err_set;

  // The block never back-pressures itself; only hold stalls the stream.
  assign s_ready  = ~hold;
  assign accept   = s_valid & ~hold;
  assign hdr_rsvd = hdr_rsvd_nonzero(s_data, LEN_WIDTH);
  assign busy     = (state != HDR);
  assign err      = err_r;

  mem_addr_incr #(
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .CMD_ADDR_WIDTH (CMD_ADDR_WIDTH)
  ) u_addr_incr (
    .addr      (addr_r),
    .addr_next (addr_inc)
  );

  always_comb begin
    state_nxt = state;
    load_hdr  = 1'b0;
    do_write  = 1'b0;
    done_set  = 1'b0;
    err_set   = '0;
    case (state)
      HDR: begin
        if (accept) begin
          load_hdr = 1'b1;
          if (hdr_rsvd) begin
            err_set[ERR_HDR] = 1'b1;
            state_nxt        = s_last ? HDR : DRAIN;
          end else if (s_last) begin
            err_set[ERR_SHORT] = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // The word that reaches cnt_r == 0 is always written, even when
          // the packet turns out to be too long; only later words are dropped.
          do_write = 1'b1;
          if (cnt_r == '0) begin
            if (s_last) begin
              done_set  = 1'b1;
              state_nxt = HDR;
            end else begin
              err_set[ERR_LONG] = 1'b1;
              state_nxt         = DRAIN;
            end
          end else if (s_last) begin
            err_set[ERR_SHORT] = 1'b1;
            state_nxt          = HDR;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HDR;
      addr_r         <= '0;
      cnt_r          <= '0;
      err_r          <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      done           <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_write_en <= do_write;
      done         <= done_set;
      // A new header replaces the sticky flags; otherwise they accumulate.
      if (load_hdr) begin
        addr_r <= s_data[MEM_ADDR_WIDTH-1:0];
        cnt_r  <= LEN_WIDTH'(hdr_len_m1(s_data, LEN_WIDTH));
        err_r  <= err_set;
      end else begin
        err_r <= err_r | err_set;
      end
      if (do_write) begin
        mem_write_addr <= addr_r;
        mem_write_data <= s_data;
        addr_r         <= addr_inc;
        cnt_r          <= cnt_r - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader
//   Self-checking bench for mem_loader. Expected writes, done pulses and
//   error flags are derived per packet from the header fields and the number
//   of payload words sent.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [12:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          neg_cnt  = 0;

  typedef struct {
    int          n;
    logic [12:0] addr;
    logic [31:0] data;
    logic        dn;
  } wr_t;

  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Address of payload word k for a burst starting at a.
  function automatic logic [12:0] exp_addr(input logic [12:0] a, input int k);
    int lo;
    if (a[12]) begin
      lo = (int'(a[11:0]) + k) % 4096;
      return {1'b1, lo[11:0]};
    end else begin
      lo = (int'(a[7:0]) + k) % 256;
      return {a[12:8], lo[7:0]};
    end
  endfunction

  // Write monitor: every observed write must match the oldest expected one,
  // one cycle after its accept.
  always @(negedge clk) begin : monitor
    wr_t e;
    neg_cnt++;
    check("s_ready", {31'd0, s_ready}, {31'd0, ~hold});
    if (mem_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", neg_cnt, e.n);
        check("wr_addr", {19'd0, mem_write_addr}, {19'd0, e.addr});
        check("wr_data", mem_write_data, e.data);
        check("wr_done", {31'd0, done}, {31'd0, e.dn});
      end
    end else if (done === 1'b1) begin
      check("done_without_write", 32'd1, 32'd0);
    end
  end

  task automatic beat(input logic [31:0] d, input logic l, input bit wr,
                      input logic [12:0] ea, input logic edn, input int hmode);
    int tries = 0;
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!acc && tries < 64) begin
      case (hmode)
        1:       hold = ~hold;
        2:       hold = 1'($urandom_range(0, 1));
        default: hold = 1'b0;
      endcase
      @(posedge clk);
      acc = !hold;
      tries++;
      if (acc && wr) exp_q.push_back('{n: neg_cnt + 1, addr: ea, data: d, dn: edn});
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else      check("busy", {31'd0, busy}, {31'd0, !l});
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int nwords, input int hmode);
    logic [12:0] a;
    int          len;
    bit          rsvd;
    logic [2:0]  eerr;
    logic [31:0] d;
    a    = hdr[12:0];
    len  = int'(hdr[25:16]) + 1;
    rsvd = (hdr[31:26] != 6'd0);
    beat(hdr, nwords == 0, 1'b0, '0, 1'b0, hmode);
    for (int k = 0; k < nwords; k++) begin
      d = $urandom;
      beat(d, k == nwords - 1, !rsvd && k < len, exp_addr(a, k),
           !rsvd && nwords == len && k == len - 1, hmode);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    hold    = 1'b0;
    if (rsvd)              eerr = 3'b100;
    else if (nwords < len) eerr = 3'b001;
    else if (nwords > len) eerr = 3'b010;
    else                   eerr = 3'b000;
    @(negedge clk);
    #1;
    check("pending_writes", exp_q.size(), 32'd0);
    check("err", {29'd0, err}, {29'd0, eerr});
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_en", {31'd0, mem_write_en}, 32'd0);
    check("rst_addr", {19'd0, mem_write_addr}, 32'd0);
    check("rst_data", mem_write_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {29'd0, err}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] hdr;
    int          len;
    int          nw;
    reset   = 1'b1;
    hold    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Plain cmd burst, then cmd/wave wrap cases
    send_pkt(32'h0003_0105, 4, 0);
    send_pkt(32'h0003_00FE, 4, 0);
    send_pkt(32'h0003_E2FE, 4, 0);
    send_pkt(32'h0001_1FFF, 2, 0);
    // Short, long, then a clean packet that clears err
    send_pkt(32'h0003_0010, 2, 0);
    send_pkt(32'h0001_0020, 5, 0);
    send_pkt(32'h0002_0030, 3, 0);
    // Header alone, hold toggling mid-burst, bad header with payload
    send_pkt(32'h0000_0040, 0, 0);
    send_pkt(32'h0007_1234, 8, 0);
    send_pkt(32'h0007_1234, 8, 1);
    send_pkt(32'h8000_0000, 3, 0);
    send_pkt(32'h8000_0000, 0, 0);
    send_pkt(32'h0000_0050, 1, 0);

    // Reset in the middle of a 6-word burst
    beat(32'h0005_0080, 1'b0, 1'b0, '0, 1'b0, 0);
    beat(32'hAAAA_0001, 1'b0, 1'b1, 13'h080, 1'b0, 0);
    beat(32'hAAAA_0002, 1'b0, 1'b1, 13'h081, 1'b0, 0);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs();
    check("rst_pending", exp_q.size(), 32'd0);
    send_pkt(32'h0005_0090, 6, 0);

    // Randomised packets
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 10);
      case ($urandom_range(0, 5))
        0:       nw = len - 1;
        1:       nw = len + int'($urandom_range(1, 3));
        2:       nw = 0;
        default: nw = len;
      endcase
      hdr = {6'd0, 10'(len - 1), 3'($urandom), 13'($urandom)};
      if ($urandom_range(0, 7) == 0) hdr[31:26] = 6'($urandom_range(1, 63));
      send_pkt(hdr, nw, ($urandom_range(0, 1) == 1) ? 2 : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
